// File: rtl/regfile_access_arbiter_if.sv
// regfile_access_arbiter_if
//   Bundles the two requester channels (core, debug), the indirect-addressing
//   context (FSR, STATUS.IRP) and the regfile port used by the arbiter.
//   slave  : arbiter side (takes requests, drives grants/responses/regfile).
//   master : requester/regfile side (drives requests and regfile read data).
interface regfile_access_arbiter_if;
  // core requester
  logic       core_req;
  logic [8:0] core_addr;
  logic       core_wr;
  logic [7:0] core_wdata;
  logic       core_gnt;
  logic       core_rvalid;
  logic [7:0] core_rdata;
  logic       core_stall;
  // debug / ICSP requester
  logic       dbg_req;
  logic [8:0] dbg_addr;
  logic       dbg_wr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt;
  logic       dbg_rvalid;
  logic [7:0] dbg_rdata;
  // indirect addressing context
  logic [7:0] fsr_val;
  logic       status_irp;
  // regfile port
  logic [8:0] rf_addr;
  logic       rf_wr_en;
  logic [7:0] rf_data_in;
  logic [7:0] rf_data_out;

  modport slave (
    input  core_req, core_addr, core_wr, core_wdata,
    input  dbg_req, dbg_addr, dbg_wr, dbg_wdata,
    input  fsr_val, status_irp, rf_data_out,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output rf_addr, rf_wr_en, rf_data_in
  );

  modport master (
    output core_req, core_addr, core_wr, core_wdata,
    output dbg_req, dbg_addr, dbg_wr, dbg_wdata,
    output fsr_val, status_irp, rf_data_out,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  rf_addr, rf_wr_en, rf_data_in
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter
//   Shares the single-port file register bank between the CPU core and the
//   debug port. At most one access is issued per cycle; core normally wins,
//   but a debug request denied STARVE_LIMIT cycles in a row is forced through.
//   INDF (addr[6:0]==0) resolves to {IRP,FSR}; INDF pointing at INDF is a
//   null access (no write, reads return 0) that is still granted/acked.
//   Read data returns one cycle after the grant, aligned to the regfile's
//   registered data_out.
// Ports
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset; all outputs forced to 0 while low
//   bus  : regfile_access_arbiter_if.slave (requests, grants, responses,
//          FSR/IRP, regfile address/write/data)
module regfile_access_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_access_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  owner_e     resp_owner_q, resp_owner_d;
  logic       resp_null_q, resp_null_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic       force_dbg, dbg_gnt, core_gnt, any_gnt, null_acc;
  logic [8:0] sel_addr, eff_addr;
  logic       sel_wr;
  logic [7:0] sel_wdata, rdata_mux;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_owner_q <= OWN_NONE;
      resp_null_q  <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      resp_owner_q <= resp_owner_d;
      resp_null_q  <= resp_null_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    // Grants are gated with rst so every output is 0 as soon as reset
    // asserts, without waiting for a clock edge.
    force_dbg = bus.dbg_req && (starve_cnt_q == LIMIT);
    dbg_gnt   = rst && bus.dbg_req && (force_dbg || !bus.core_req);
    core_gnt  = rst && bus.core_req && !dbg_gnt;
    any_gnt   = dbg_gnt || core_gnt;

    sel_addr  = dbg_gnt ? bus.dbg_addr  : bus.core_addr;
    sel_wr    = dbg_gnt ? bus.dbg_wr    : bus.core_wr;
    sel_wdata = dbg_gnt ? bus.dbg_wdata : bus.core_wdata;

    // INDF in any bank goes through {IRP,FSR}; a direct address can never
    // have eff[6:0]==0, so this only catches FSR pointing back at INDF.
    eff_addr  = (sel_addr[6:0] == 7'd0) ? {bus.status_irp, bus.fsr_val} : sel_addr;
    null_acc  = any_gnt && (eff_addr[6:0] == 7'd0);

    bus.dbg_gnt    = dbg_gnt;
    bus.core_gnt   = core_gnt;
    bus.core_stall = rst && bus.core_req && dbg_gnt;
    bus.rf_addr    = any_gnt ? eff_addr : 9'd0;
    bus.rf_data_in = any_gnt ? sel_wdata : 8'd0;
    bus.rf_wr_en   = any_gnt && sel_wr && !null_acc;

    // Saturating count of consecutive denied debug cycles.
    starve_cnt_d = starve_cnt_q;
    if (!bus.dbg_req || dbg_gnt)   starve_cnt_d = 4'd0;
    else if (starve_cnt_q < LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;

    resp_owner_d = OWN_NONE;
    if (dbg_gnt)       resp_owner_d = OWN_DBG;
    else if (core_gnt) resp_owner_d = OWN_CORE;
    resp_null_d  = null_acc;

    // Response stage: the regfile's registered data_out lines up with the
    // access issued last cycle.
    rdata_mux       = resp_null_q ? 8'h00 : bus.rf_data_out;
    bus.core_rvalid = (resp_owner_q == OWN_CORE);
    bus.dbg_rvalid  = (resp_owner_q == OWN_DBG);
    bus.core_rdata  = bus.core_rvalid ? rdata_mux : 8'h00;
    bus.dbg_rdata   = bus.dbg_rvalid  ? rdata_mux : 8'h00;
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
module tb_regfile_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_access_arbiter_if bus ();

  regfile_access_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Regfile model: registered read (old data on write), preload port for setup.
  logic [7:0] mem [0:511];
  logic       pl_en = 1'b0;
  logic [8:0] pl_addr = 9'd0;
  logic [7:0] pl_data = 8'd0;
  always @(posedge clk) begin
    if (pl_en)             mem[pl_addr] <= pl_data;
    else if (bus.rf_wr_en) mem[bus.rf_addr] <= bus.rf_data_in;
    bus.rf_data_out <= mem[bus.rf_addr];
  end

  // Bench-side expected contents.
  logic [7:0] shadow [0:511];

  typedef struct {
    bit         dbg;
    bit         chk;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  // Response monitor: pops the scoreboard on the cycle a response is due,
  // otherwise requires both rvalids low.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      tests++;
      if (bus.core_rvalid !== !e.dbg || bus.dbg_rvalid !== e.dbg) begin
        fails++;
        $display("FAIL rsp_channel cyc=%0d got core_rvalid=%b dbg_rvalid=%b want dbg=%b",
                 cyc, bus.core_rvalid, bus.dbg_rvalid, e.dbg);
      end
      tests++;
      if ((e.dbg ? bus.core_rdata : bus.dbg_rdata) !== 8'h00) begin
        fails++;
        $display("FAIL rsp_nonowner_rdata cyc=%0d got %h want 00", cyc,
                 e.dbg ? bus.core_rdata : bus.dbg_rdata);
      end
      if (e.chk) begin
        tests++;
        if ((e.dbg ? bus.dbg_rdata : bus.core_rdata) !== e.data) begin
          fails++;
          $display("FAIL rsp_rdata cyc=%0d got %h want %h", cyc,
                   e.dbg ? bus.dbg_rdata : bus.core_rdata, e.data);
        end
      end
    end else begin
      tests++;
      if (bus.core_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
        fails++;
        $display("FAIL rsp_spurious cyc=%0d got core_rvalid=%b dbg_rvalid=%b want 0 0",
                 cyc, bus.core_rvalid, bus.dbg_rvalid);
      end
    end
  end

  task automatic drive_core(input bit req, input logic [8:0] a, input bit wr, input logic [7:0] d);
    bus.core_req = req; bus.core_addr = a; bus.core_wr = wr; bus.core_wdata = d;
  endtask

  task automatic drive_dbg(input bit req, input logic [8:0] a, input bit wr, input logic [7:0] d);
    bus.dbg_req = req; bus.dbg_addr = a; bus.dbg_wr = wr; bus.dbg_wdata = d;
  endtask

  task automatic push_rsp(input bit dbg, input bit chk, input logic [7:0] d);
    exp_t x;
    x.dbg = dbg; x.chk = chk; x.data = d; x.due = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_core(1'b0, 9'd0, 1'b0, 8'd0);
      drive_dbg(1'b0, 9'd0, 1'b0, 8'd0);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    shadow[a] = d;
  endtask

  task automatic test_reset();
    bus.fsr_val = 8'h00; bus.status_irp = 1'b0;
    drive_core(1'b1, 9'h020, 1'b1, 8'h11);
    drive_dbg(1'b1, 9'h030, 1'b1, 8'h22);
    preload(9'h020, 8'hA5);
    preload(9'h030, 8'h5A);
    preload(9'h080, 8'h77);
    for (int i = 0; i < 8; i++) preload(9'h040 + 9'(i), 8'(i * 17 + 3));
    @(negedge clk);
    pl_en = 1'b0;
    #1;
    tests++;
    if ({bus.core_gnt, bus.dbg_gnt, bus.core_stall, bus.rf_wr_en, bus.core_rvalid, bus.dbg_rvalid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl got gnt=%b%b stall=%b wr_en=%b rvalid=%b%b want all 0",
               bus.core_gnt, bus.dbg_gnt, bus.core_stall, bus.rf_wr_en, bus.core_rvalid, bus.dbg_rvalid);
    end
    tests++;
    if ({bus.rf_addr, bus.rf_data_in, bus.core_rdata, bus.dbg_rdata} !== 33'd0) begin
      fails++;
      $display("FAIL reset_data got rf_addr=%h rf_data_in=%h core_rdata=%h dbg_rdata=%h want 0",
               bus.rf_addr, bus.rf_data_in, bus.core_rdata, bus.dbg_rdata);
    end
    drive_core(1'b0, 9'd0, 1'b0, 8'd0);
    drive_dbg(1'b0, 9'd0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_core_read();
    @(negedge clk);
    drive_core(1'b1, 9'h020, 1'b0, 8'h00);
    #1;
    tests++;
    if (bus.core_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0 || bus.core_stall !== 1'b0) begin
      fails++;
      $display("FAIL core_read_gnt got core=%b dbg=%b stall=%b want 1 0 0",
               bus.core_gnt, bus.dbg_gnt, bus.core_stall);
    end
    tests++;
    if (bus.rf_addr !== 9'h020 || bus.rf_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL core_read_rf got addr=%h wr_en=%b want 020 0", bus.rf_addr, bus.rf_wr_en);
    end
    push_rsp(1'b0, 1'b1, 8'hA5);
    idle(2);
  endtask

  task automatic test_starve();
    bit want_dbg;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_core(1'b1, 9'h020, 1'b0, 8'h00);
      drive_dbg(1'b1, 9'h030, 1'b0, 8'h00);
      #1;
      want_dbg = (i % 5 == 4);
      tests++;
      if (bus.dbg_gnt !== want_dbg || bus.core_gnt !== !want_dbg || bus.core_stall !== want_dbg) begin
        fails++;
        $display("FAIL starve_i%0d got dbg_gnt=%b core_gnt=%b stall=%b want dbg_gnt=%b",
                 i, bus.dbg_gnt, bus.core_gnt, bus.core_stall, want_dbg);
      end
      push_rsp(want_dbg, 1'b1, want_dbg ? shadow[9'h030] : shadow[9'h020]);
    end
    idle(2);
  endtask

  task automatic test_indirect();
    @(negedge clk);
    bus.fsr_val = 8'h21; bus.status_irp = 1'b1;
    drive_core(1'b1, 9'h180, 1'b1, 8'h3C);
    #1;
    tests++;
    if (bus.core_gnt !== 1'b1 || bus.rf_addr !== 9'h121 || bus.rf_wr_en !== 1'b1 || bus.rf_data_in !== 8'h3C) begin
      fails++;
      $display("FAIL indf_write got gnt=%b addr=%h wr_en=%b data=%h want 1 121 1 3c",
               bus.core_gnt, bus.rf_addr, bus.rf_wr_en, bus.rf_data_in);
    end
    push_rsp(1'b0, 1'b0, 8'h00);
    shadow[9'h121] = 8'h3C;
    @(negedge clk);
    drive_core(1'b1, 9'h121, 1'b0, 8'h00);
    #1;
    tests++;
    if (bus.rf_addr !== 9'h121 || bus.rf_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL direct_read_rf got addr=%h wr_en=%b want 121 0", bus.rf_addr, bus.rf_wr_en);
    end
    push_rsp(1'b0, 1'b1, shadow[9'h121]);
    @(negedge clk);
    bus.fsr_val = 8'h20; bus.status_irp = 1'b0;
    drive_core(1'b1, 9'h080, 1'b0, 8'h00);
    #1;
    tests++;
    if (bus.rf_addr !== 9'h020 || bus.rf_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL indf_bank1_rf got addr=%h wr_en=%b want 020 0", bus.rf_addr, bus.rf_wr_en);
    end
    push_rsp(1'b0, 1'b1, shadow[9'h020]);
    idle(2);
  endtask

  task automatic test_null();
    @(negedge clk);
    bus.fsr_val = 8'h80; bus.status_irp = 1'b0;
    drive_dbg(1'b1, 9'h000, 1'b1, 8'hFF);
    #1;
    tests++;
    if (bus.dbg_gnt !== 1'b1 || bus.rf_wr_en !== 1'b0 || bus.rf_addr !== 9'h080) begin
      fails++;
      $display("FAIL null_write got gnt=%b wr_en=%b addr=%h want 1 0 080",
               bus.dbg_gnt, bus.rf_wr_en, bus.rf_addr);
    end
    push_rsp(1'b1, 1'b1, 8'h00);
    // Regfile holds 0x77 at 0x080, so a non-zero read here means the null
    // access leaked regfile data.
    @(negedge clk);
    drive_dbg(1'b1, 9'h100, 1'b0, 8'h00);
    #1;
    tests++;
    if (bus.dbg_gnt !== 1'b1 || bus.rf_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL null_read_gnt got gnt=%b wr_en=%b want 1 0", bus.dbg_gnt, bus.rf_wr_en);
    end
    push_rsp(1'b1, 1'b1, 8'h00);
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [8:0] a;
    bus.fsr_val = 8'h00; bus.status_irp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = (i == 6) ? 9'h043 : 9'h040 + 9'(i);
      if (i % 2 == 0) begin
        drive_core(1'b0, 9'd0, 1'b0, 8'd0);
        drive_dbg(1'b1, a, 1'b0, 8'h00);
      end else begin
        drive_dbg(1'b0, 9'd0, 1'b0, 8'd0);
        drive_core(1'b1, a, (i == 3), 8'hE0);
      end
      #1;
      tests++;
      if (bus.dbg_gnt !== (i % 2 == 0) || bus.core_gnt !== (i % 2 == 1) || bus.rf_addr !== a) begin
        fails++;
        $display("FAIL b2b_i%0d got dbg_gnt=%b core_gnt=%b addr=%h want addr=%h",
                 i, bus.dbg_gnt, bus.core_gnt, bus.rf_addr, a);
      end
      if (i == 3) begin
        push_rsp(1'b0, 1'b0, 8'h00);
        shadow[a] = 8'hE0;
      end else begin
        push_rsp(i % 2 == 0, 1'b1, shadow[a]);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_core(1'b1, 9'h020, 1'b0, 8'h00);
    drive_dbg(1'b1, 9'h030, 1'b1, 8'h99);
    bus.core_req = 1'b1;
    drive_dbg(1'b0, 9'd0, 1'b0, 8'd0);
    #1;
    tests++;
    if (bus.core_gnt !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_pre_gnt got %b want 1", bus.core_gnt);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.core_gnt, bus.dbg_gnt, bus.core_stall, bus.rf_wr_en, bus.rf_addr, bus.rf_data_in,
         bus.core_rvalid, bus.dbg_rvalid, bus.core_rdata, bus.dbg_rdata} !== 39'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs got gnt=%b%b addr=%h data=%h rvalid=%b%b want all 0",
               bus.core_gnt, bus.dbg_gnt, bus.rf_addr, bus.rf_data_in, bus.core_rvalid, bus.dbg_rvalid);
    end
    @(posedge clk);
    #2;
    tests++;
    if (bus.core_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_rvalid got %b want 0", bus.core_rvalid);
    end
    idle(2);
    rst = 1'b1;
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    drive_core(1'b0, 9'd0, 1'b0, 8'd0);
    drive_dbg(1'b0, 9'd0, 1'b0, 8'd0);
    bus.fsr_val = 8'h00; bus.status_irp = 1'b0;
    test_reset();
    test_core_read();
    test_starve();
    test_indirect();
    test_null();
    test_back_to_back();
    test_reset_mid();
    idle(2);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
